// File: rtl/elevator_scheduler.sv
// Three-floor elevator call scheduler: latches floor calls, issues single-cycle
// step commands toward them and holds the door open for DOOR_CYCLES per stop.
module elevator_scheduler #(
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call_req,
    input  logic [1:0] floor,
    output logic       up_request,
    output logic       down_request,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       dir,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        ARRIVE = 2'd2,
        DOOR   = 2'd3
    } state_t;

    state_t     state_r;
    logic [7:0] door_cnt_r;

    logic       floor_ok_s;
    logic [2:0] floor_mask_s;
    logic [2:0] above_mask_s;
    logic [2:0] below_mask_s;
    logic       here_s;
    logic       above_s;
    logic       below_s;
    logic       go_door_s;
    logic       go_step_s;
    logic       step_dir_s;
    logic [2:0] clear_s;
    logic [2:0] pending_next_s;

    assign floor_ok_s     = (floor != 2'b11);
    assign floor_mask_s   = 3'b001 << floor;
    assign here_s         = |(pending & floor_mask_s);
    assign above_s        = |(pending & above_mask_s);
    assign below_s        = |(pending & below_mask_s);
    assign pending_next_s = (pending | call_req) & ~clear_s;

    // Floors lying above and below the current one; an invalid floor sees no calls.
    always_comb begin
        case (floor)
            2'd0: begin above_mask_s = 3'b110; below_mask_s = 3'b000; end
            2'd1: begin above_mask_s = 3'b100; below_mask_s = 3'b001; end
            2'd2: begin above_mask_s = 3'b000; below_mask_s = 3'b011; end
            default: begin above_mask_s = 3'b000; below_mask_s = 3'b000; end
        endcase
    end

    // Stop here first, else keep direction, else reverse; no calls above floor 2 forces reversal.
    always_comb begin
        go_door_s  = 1'b0;
        go_step_s  = 1'b0;
        step_dir_s = dir;
        if (here_s) begin
            go_door_s = 1'b1;
        end else if (dir ? above_s : below_s) begin
            go_step_s = 1'b1;
        end else if (dir ? below_s : above_s) begin
            go_step_s  = 1'b1;
            step_dir_s = ~dir;
        end else begin
            go_step_s = 1'b0;
        end
    end

    // The served floor's call is dropped on DOOR entry and throughout DOOR.
    always_comb begin
        if (!floor_ok_s) begin
            clear_s = 3'b000;
        end else if (state_r == DOOR) begin
            clear_s = floor_mask_s;
        end else if (((state_r == IDLE) || (state_r == ARRIVE)) && go_door_s) begin
            clear_s = floor_mask_s;
        end else begin
            clear_s = 3'b000;
        end
    end

    // Scheduler state and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pending      <= 3'b000;
            dir          <= 1'b1;
            door_cnt_r   <= 8'd0;
            up_request   <= 1'b0;
            down_request <= 1'b0;
            door_open    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pending      <= pending_next_s;
            up_request   <= 1'b0;
            down_request <= 1'b0;
            if (!floor_ok_s) begin
                state_r    <= IDLE;
                door_cnt_r <= 8'd0;
                door_open  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, ARRIVE: begin
                        if (go_door_s) begin
                            state_r    <= DOOR;
                            door_cnt_r <= 8'(DOOR_CYCLES);
                            door_open  <= 1'b1;
                            busy       <= 1'b1;
                        end else if (go_step_s) begin
                            state_r      <= STEP;
                            dir          <= step_dir_s;
                            up_request   <= step_dir_s;
                            down_request <= ~step_dir_s;
                            door_open    <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            state_r   <= IDLE;
                            door_open <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    STEP: begin
                        state_r   <= ARRIVE;
                        door_open <= 1'b0;
                        busy      <= 1'b1;
                    end
                    DOOR: begin
                        // The counter holds the door cycles still to run, including this one.
                        if (door_cnt_r <= 8'd1) begin
                            state_r    <= IDLE;
                            door_cnt_r <= 8'd0;
                            door_open  <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            door_cnt_r <= door_cnt_r - 8'd1;
                            door_open  <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        door_open <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: vector table, directed corner
// sequences, and random calls checked against a floor-level reference model.
module tb_elevator_scheduler;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] call_req = 3'b000;
    logic [1:0] floor = 2'd0;
    logic       up_request, down_request, door_open, dir, busy;
    logic [2:0] pending;

    int n_checks = 0;
    int n_pass = 0;

    elevator_scheduler #(.DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .floor(floor),
        .up_request(up_request), .down_request(down_request), .door_open(door_open),
        .pending(pending), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] call;
        logic [1:0] fl;
        logic [6:0] exp;   // {up, down, door, busy, pending}
    } vec_t;

    vec_t tbl [23];

    // Reference model state: calls outstanding, door cycles left, car motion.
    bit [2:0] m_pend;
    int       m_door;
    bit       m_moving, m_arrived, m_dir;
    bit       need_move, need_dir;
    int       car;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, act, exp);
    endtask

    function automatic logic [6:0] outs7();
        return {up_request, down_request, door_open, busy, pending};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_check(input string tag, input logic [2:0] c, input logic [1:0] fl,
                               input logic [6:0] exp);
        call_req = c;
        floor = fl;
        tick();
        check(tag, {1'b0, outs7()}, {1'b0, exp});
    endtask

    task automatic do_reset(input logic [1:0] fl);
        call_req = 3'b000;
        floor = fl;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // 0 nothing, 1 open here, 2 go up, 3 go down.
    function automatic int pick(input bit [2:0] p, input int f, input bit d);
        bit up_any = 1'b0;
        bit dn_any = 1'b0;
        if (p[f]) return 1;
        for (int i = 0; i < 3; i++) begin
            if (p[i] && i > f) up_any = 1'b1;
            if (p[i] && i < f) dn_any = 1'b1;
        end
        if (d && up_any) return 2;
        if (!d && dn_any) return 3;
        if (up_any) return 2;
        if (dn_any) return 3;
        return 0;
    endfunction

    task automatic model_step(input bit [2:0] c, input logic [1:0] fl);
        int act;
        if (m_moving) begin
            need_move = 1'b1;
            need_dir  = m_dir;
        end
        if (fl == 2'b11) begin
            m_pend = m_pend | c;
            m_door = 0;
            m_moving = 1'b0;
            m_arrived = 1'b0;
        end else if (m_door > 0) begin
            m_door--;
            m_pend = m_pend | c;
            m_pend[fl] = 1'b0;
        end else if (m_moving) begin
            m_moving = 1'b0;
            m_arrived = 1'b1;
            m_pend = m_pend | c;
        end else begin
            act = pick(m_pend, int'(fl), m_dir);
            m_pend = m_pend | c;
            m_arrived = 1'b0;
            case (act)
                1: begin m_door = DC; m_pend[fl] = 1'b0; end
                2: begin m_moving = 1'b1; m_dir = 1'b1; end
                3: begin m_moving = 1'b1; m_dir = 1'b0; end
                default: ;
            endcase
        end
    endtask

    initial begin
        bit       seen;
        int       inj_left;
        bit [2:0] c;
        logic [7:0] exp8;

        tbl = '{
            '{3'b001, 2'd0, 7'b0000_001}, '{3'b000, 2'd0, 7'b0011_000},
            '{3'b000, 2'd0, 7'b0011_000}, '{3'b000, 2'd0, 7'b0011_000},
            '{3'b000, 2'd0, 7'b0011_000}, '{3'b000, 2'd0, 7'b0000_000},
            '{3'b100, 2'd0, 7'b0000_100}, '{3'b000, 2'd0, 7'b1001_100},
            '{3'b000, 2'd0, 7'b0001_100}, '{3'b000, 2'd1, 7'b1001_100},
            '{3'b000, 2'd1, 7'b0001_100}, '{3'b000, 2'd2, 7'b0011_000},
            '{3'b000, 2'd2, 7'b0011_000}, '{3'b000, 2'd2, 7'b0011_000},
            '{3'b000, 2'd2, 7'b0011_000}, '{3'b000, 2'd2, 7'b0000_000},
            '{3'b100, 2'd2, 7'b0000_100}, '{3'b100, 2'd2, 7'b0011_000},
            '{3'b100, 2'd2, 7'b0011_000}, '{3'b100, 2'd2, 7'b0011_000},
            '{3'b100, 2'd2, 7'b0011_000}, '{3'b100, 2'd2, 7'b0000_000},
            '{3'b000, 2'd2, 7'b0000_000}
        };

        // Reset state.
        do_reset(2'd0);
        check("reset_state", {dir, outs7()}, 8'b1_0000_000);

        // Stop at current floor, two-floor trip, call held through DOOR.
        for (int i = 0; i < 23; i++)
            drive_check($sformatf("table[%0d]", i), tbl[i].call, tbl[i].fl, tbl[i].exp);

        // Calls both ways from floor 1 heading up: floor 2 first, then down to 0.
        do_reset(2'd1);
        drive_check("both_latch", 3'b101, 2'd1, 7'b0000_101);
        drive_check("both_up",    3'b000, 2'd1, 7'b1001_101);
        check("both_dir_up", {7'b0, dir}, 8'd1);
        drive_check("both_arr1",  3'b000, 2'd1, 7'b0001_101);
        for (int i = 0; i < DC; i++)
            drive_check($sformatf("both_door2[%0d]", i), 3'b000, 2'd2, 7'b0011_001);
        drive_check("both_idle2", 3'b000, 2'd2, 7'b0000_001);
        drive_check("both_dn1",   3'b000, 2'd2, 7'b0101_001);
        check("both_dir_dn", {7'b0, dir}, 8'd0);
        drive_check("both_arr_a", 3'b000, 2'd2, 7'b0001_001);
        drive_check("both_dn2",   3'b000, 2'd1, 7'b0101_001);
        drive_check("both_arr_b", 3'b000, 2'd1, 7'b0001_001);
        drive_check("both_door0", 3'b000, 2'd0, 7'b0011_000);

        // Reset pulsed in the STEP cycle acts without a clock edge.
        do_reset(2'd0);
        drive_check("rst_latch", 3'b100, 2'd0, 7'b0000_100);
        drive_check("rst_step",  3'b000, 2'd0, 7'b1001_100);
        reset = 1'b1;
        #1;
        check("rst_async", {1'b0, outs7()}, 8'b0000_0000);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            drive_check($sformatf("rst_quiet[%0d]", i), 3'b000, 2'd0, 7'b0000_000);

        // Invalid floor holds the call and issues nothing; valid floor serves it.
        drive_check("inv_latch", 3'b010, 2'b11, 7'b0000_010);
        for (int i = 0; i < 3; i++)
            drive_check($sformatf("inv_hold[%0d]", i), 3'b000, 2'b11, 7'b0000_010);
        floor = 2'd1;
        seen = 1'b0;
        for (int t = 0; t < 2 && !seen; t++) begin
            tick();
            if (door_open) seen = 1'b1;
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL inv_restore: door_open not seen within 2 cycles, got %b expected 1", door_open);
        check("inv_cleared", {5'b0, pending}, 8'b0000_0000);

        // Random calls and brief invalid-floor glitches against the reference model.
        do_reset(2'd0);
        m_pend = 3'b000; m_door = 0; m_moving = 1'b0; m_arrived = 1'b0; m_dir = 1'b1;
        need_move = 1'b0; need_dir = 1'b0; car = 0; inj_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (need_move) begin
                car = need_dir ? car + 1 : car - 1;
                if (car < 0) car = 0;
                if (car > 2) car = 2;
                need_move = 1'b0;
            end
            if (inj_left > 0) inj_left--;
            else if ($urandom_range(0, 63) == 0) inj_left = int'($urandom_range(1, 3));
            c = 3'b000;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) c[b] = 1'b1;
            call_req = c;
            floor = (inj_left > 0) ? 2'b11 : car[1:0];
            model_step(c, floor);
            tick();
            exp8 = {m_dir, m_moving & m_dir, m_moving & ~m_dir, (m_door > 0),
                    (m_door > 0) | m_moving | m_arrived, m_pend};
            check($sformatf("rand[%0d]", i), {dir, outs7()}, exp8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
